ex_wb_collector: RTL and testbench

//  Receiving end of the execution-unit result interface (ex_update). Collects
//  up to NUM_FU completions per cycle from FUs that cannot stall (ALU, DIV, MUL).

---
 rtl/ex_wb_collector_pkg.sv | 21 ++
 rtl/ex_wb_collector_mw_fifo.sv | 90 +++++++++
 rtl/ex_wb_collector.sv | 83 ++++++++
 tb/tb_ex_wb_collector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_collector_pkg.sv
// Shared core types for the execution-unit result path.
// Holds the ex_update bundle and the writeback stall margin.
package ex_wb_collector_pkg;

  localparam int R_ADDR          = 6;
  localparam int ROB_INDEX_BITS  = 3;
  localparam int XLEN            = 32;
  localparam int CAUSE_BITS      = 6;
  localparam int CORE_NUM_FU     = 2;
  localparam int WB_STALL_MARGIN = 2 * CORE_NUM_FU;

  typedef struct packed {
    logic                      valid;
    logic [R_ADDR-1:0]         dest;
    logic [ROB_INDEX_BITS-1:0] ticket;
    logic [XLEN-1:0]           data;
    logic                      valid_exception;
    logic [CAUSE_BITS-1:0]     cause;
  } ex_update;

endpackage

// File: rtl/ex_wb_collector_mw_fifo.sv
// NUM_FU-write / 1-read circular buffer with count and next-state counts.
// Ports: clk, rst, flush, wr_data[NUM_FU], pop -> count, count_next, free_next, peek_next, drop.
module mw_fifo
  import ex_wb_collector_pkg::*;
#(
  parameter int NUM_FU = CORE_NUM_FU,
  parameter int DEPTH  = 8,
  parameter int PW     = $clog2(DEPTH),
  parameter int CW     = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  ex_update      wr_data [NUM_FU],
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic [CW-1:0] free_next,
  output ex_update      peek_next,
  output logic          drop
);

  ex_update        mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   free_eff;
  logic [CW-1:0]   n_acc;
  logic [CW-1:0]   rem;
  logic [NUM_FU-1:0] we;
  logic [PW-1:0]   waddr [NUM_FU];
  ex_update        first_data;
  logic            have_first;

  // A same-cycle pop frees its slot for this cycle's writes.
  // Accepted writes pack densely from tail in port order.
  always_comb begin
    free_eff   = CW'(DEPTH) - cnt + CW'(pop);
    n_acc      = '0;
    we         = '0;
    drop       = 1'b0;
    first_data = '0;
    have_first = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      waddr[k] = tail + n_acc[PW-1:0];
      if (wr_data[k].valid && !flush) begin
        if (n_acc < free_eff) begin
          we[k] = 1'b1;
          n_acc = n_acc + CW'(1);
          if (!have_first) begin
            first_data = wr_data[k];
            have_first = 1'b1;
          end
        end else begin
          drop = 1'b1;
        end
      end
    end
    head_nxt = head + PW'(pop);
    rem      = cnt - CW'(pop);
    // If the buffer drains this cycle, the new head is the first write.
    peek_next  = (rem == '0) ? first_data : mem[head_nxt];
    count_next = flush ? '0 : rem + n_acc;
    free_next  = CW'(DEPTH) - count_next;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail + n_acc[PW-1:0];
      cnt  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_FU; k++) begin
      if (!rst && we[k]) begin
        mem[waddr[k]] <= wr_data[k];
      end
    end
  end

  assign count = cnt;

endmodule

// File: rtl/ex_wb_collector.sv
// Collects non-stalling FU results, drains one per cycle to writeback.
// Ports: clk, rst, flush_i, fu_update_i[NUM_FU], wb_valid_o/wb_ready_i/wb_update_o, stall_issue_o, occupancy_o, overflow_o.
module ex_wb_collector
  import ex_wb_collector_pkg::*;
#(
  parameter int NUM_FU = CORE_NUM_FU,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  ex_update                 fu_update_i [NUM_FU],
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output ex_update                 wb_update_o,
  output logic                     stall_issue_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     overflow_o
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int MARGIN = 2 * NUM_FU;

  ex_update      wb_q;
  ex_update      wb_d;
  ex_update      peek;
  logic          pop;
  logic          drop;
  logic          stall_q;
  logic          ovf_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] free_nxt;

  assign pop = wb_q.valid & wb_ready_i;

  mw_fifo #(
    .NUM_FU (NUM_FU),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_i),
    .wr_data    (fu_update_i),
    .pop        (pop),
    .count      (cnt),
    .count_next (cnt_nxt),
    .free_next  (free_nxt),
    .peek_next  (peek),
    .drop       (drop)
  );

  // Output register mirrors the next head entry.
  always_comb begin
    wb_d = '0;
    if (!flush_i && cnt_nxt != '0) begin
      wb_d       = peek;
      wb_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q    <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      stall_q <= free_nxt < CW'(MARGIN);
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign wb_valid_o    = wb_q.valid;
  assign wb_update_o   = wb_q;
  assign stall_issue_o = stall_q;
  assign occupancy_o   = cnt;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_ex_wb_collector.sv
// Directed self-checking bench for ex_wb_collector.
// Each task drives one scenario and checks its own expectations.
module tb_ex_wb_collector;
  import ex_wb_collector_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_i;
  ex_update   fu [2];
  logic       wb_valid_o;
  logic       wb_ready_i;
  ex_update   wb_update_o;
  logic       stall_issue_o;
  logic [3:0] occupancy_o;
  logic       overflow_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_wb_collector dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .fu_update_i   (fu),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_update_o   (wb_update_o),
    .stall_issue_o (stall_issue_o),
    .occupancy_o   (occupancy_o),
    .overflow_o    (overflow_o)
  );

  function automatic ex_update mk(input logic [5:0] d,
                                  input logic [2:0] t,
                                  input logic [31:0] x);
    mk        = '0;
    mk.valid  = 1'b1;
    mk.dest   = d;
    mk.ticket = t;
    mk.data   = x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    fu[0] = '0;
    fu[1] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b1;
    idle_in();
    fu[0] = mk(6'd1, 3'd1, 32'hdead);
    step();
    step();
    rst = 1'b0;
    idle_in();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", wb_valid_o); end
    checks++; if (wb_update_o !== '0) begin errors++; $display("FAIL rst_update got %0h want 0", wb_update_o); end
    checks++; if (stall_issue_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall_issue_o); end
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", occupancy_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b want 0", overflow_o); end
    step();
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL rst_nostore_occ got %0d want 0", occupancy_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_nostore_valid got %0b want 0", wb_valid_o); end
  endtask

  task automatic test_single();
    wb_ready_i = 1'b1;
    fu[0] = mk(6'd5, 3'd3, 32'h1234);
    step();
    idle_in();
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", wb_valid_o); end
    checks++; if (wb_update_o.dest !== 6'd5) begin errors++; $display("FAIL single_dest got %0d want 5", wb_update_o.dest); end
    checks++; if (wb_update_o.ticket !== 3'd3) begin errors++; $display("FAIL single_ticket got %0d want 3", wb_update_o.ticket); end
    checks++; if (wb_update_o.data !== 32'h1234) begin errors++; $display("FAIL single_data got %0h want 1234", wb_update_o.data); end
    checks++; if (wb_update_o.valid !== 1'b1) begin errors++; $display("FAIL single_fvalid got %0b want 1", wb_update_o.valid); end
    checks++; if (occupancy_o !== 4'd1) begin errors++; $display("FAIL single_occ got %0d want 1", occupancy_o); end
    step();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL single_drop got %0b want 0", wb_valid_o); end
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL single_occ0 got %0d want 0", occupancy_o); end
  endtask

  task automatic test_pair();
    ex_update b;
    b = mk(6'd9, 3'd6, 32'hbbbb);
    b.valid_exception = 1'b1;
    b.cause = 6'h2a;
    wb_ready_i = 1'b1;
    fu[0] = mk(6'd8, 3'd5, 32'haaaa);
    fu[1] = b;
    step();
    idle_in();
    checks++; if (wb_update_o.data !== 32'haaaa) begin errors++; $display("FAIL pair_a got %0h want aaaa", wb_update_o.data); end
    checks++; if (occupancy_o !== 4'd2) begin errors++; $display("FAIL pair_occ2 got %0d want 2", occupancy_o); end
    step();
    checks++; if (wb_update_o.data !== 32'hbbbb) begin errors++; $display("FAIL pair_b got %0h want bbbb", wb_update_o.data); end
    checks++; if (wb_update_o.cause !== 6'h2a) begin errors++; $display("FAIL pair_cause got %0h want 2a", wb_update_o.cause); end
    checks++; if (wb_update_o.valid_exception !== 1'b1) begin errors++; $display("FAIL pair_exc got %0b want 1", wb_update_o.valid_exception); end
    checks++; if (occupancy_o !== 4'd1) begin errors++; $display("FAIL pair_occ1 got %0d want 1", occupancy_o); end
    step();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL pair_empty got %0b want 0", wb_valid_o); end
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL pair_occ0 got %0d want 0", occupancy_o); end
  endtask

  task automatic test_backpressure();
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fu[0] = mk(6'd1, 3'd0, 32'd100 + 32'(2 * i));
      fu[1] = mk(6'd2, 3'd1, 32'd101 + 32'(2 * i));
      step();
      checks++; if (occupancy_o !== 4'(2 * (i + 1))) begin errors++; $display("FAIL bp_occ%0d got %0d want %0d", i, occupancy_o, 2 * (i + 1)); end
      checks++; if (stall_issue_o !== (i >= 2)) begin errors++; $display("FAIL bp_stall%0d got %0b want %0b", i, stall_issue_o, i >= 2); end
      checks++; if (wb_update_o.data !== 32'd100) begin errors++; $display("FAIL bp_hold%0d got %0d want 100", i, wb_update_o.data); end
    end
    idle_in();
    wb_ready_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      checks++; if (wb_valid_o !== 1'b1 || wb_update_o.data !== 32'd100 + 32'(j)) begin errors++; $display("FAIL bp_drain%0d got %0b/%0d want 1/%0d", j, wb_valid_o, wb_update_o.data, 100 + j); end
      step();
    end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", wb_valid_o); end
    checks++; if (stall_issue_o !== 1'b0) begin errors++; $display("FAIL bp_unstall got %0b want 0", stall_issue_o); end
  endtask

  task automatic test_full_pop_push();
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fu[0] = mk(6'd3, 3'd0, 32'd200 + 32'(2 * i));
      fu[1] = mk(6'd4, 3'd1, 32'd201 + 32'(2 * i));
      step();
    end
    checks++; if (occupancy_o !== 4'd8) begin errors++; $display("FAIL full_occ got %0d want 8", occupancy_o); end
    wb_ready_i = 1'b1;
    fu[0] = mk(6'd3, 3'd2, 32'd208);
    fu[1] = '0;
    step();
    checks++; if (occupancy_o !== 4'd8) begin errors++; $display("FAIL full_push1_occ got %0d want 8", occupancy_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL full_push1_ovf got %0b want 0", overflow_o); end
    checks++; if (wb_update_o.data !== 32'd201) begin errors++; $display("FAIL full_push1_head got %0d want 201", wb_update_o.data); end
    fu[0] = mk(6'd3, 3'd3, 32'd209);
    fu[1] = mk(6'd4, 3'd4, 32'd210);
    step();
    idle_in();
    checks++; if (occupancy_o !== 4'd8) begin errors++; $display("FAIL full_push2_occ got %0d want 8", occupancy_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL full_push2_ovf got %0b want 1", overflow_o); end
    for (int j = 0; j < 8; j++) begin
      checks++; if (wb_valid_o !== 1'b1 || wb_update_o.data !== 32'd202 + 32'(j)) begin errors++; $display("FAIL full_drain%0d got %0b/%0d want 1/%0d", j, wb_valid_o, wb_update_o.data, 202 + j); end
      step();
    end
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL full_occ0 got %0d want 0", occupancy_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL full_sticky got %0b want 1", overflow_o); end
  endtask

  task automatic test_flush();
    wb_ready_i = 1'b0;
    fu[0] = mk(6'd7, 3'd0, 32'd300);
    fu[1] = mk(6'd7, 3'd1, 32'd301);
    step();
    fu[0] = mk(6'd7, 3'd2, 32'd302);
    fu[1] = mk(6'd7, 3'd3, 32'd303);
    step();
    fu[0] = mk(6'd7, 3'd4, 32'd304);
    fu[1] = '0;
    step();
    checks++; if (occupancy_o !== 4'd5) begin errors++; $display("FAIL flush_pre_occ got %0d want 5", occupancy_o); end
    checks++; if (stall_issue_o !== 1'b1) begin errors++; $display("FAIL flush_pre_stall got %0b want 1", stall_issue_o); end
    flush_i = 1'b1;
    fu[0] = mk(6'd7, 3'd5, 32'd305);
    step();
    flush_i = 1'b0;
    idle_in();
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", occupancy_o); end
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", wb_valid_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL flush_ovf got %0b want 1", overflow_o); end
    checks++; if (stall_issue_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", stall_issue_o); end
    step();
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL flush_lost got %0d want 0", occupancy_o); end
    wb_ready_i = 1'b1;
    fu[1] = mk(6'd7, 3'd6, 32'd400);
    step();
    idle_in();
    checks++; if (wb_valid_o !== 1'b1 || wb_update_o.data !== 32'd400) begin errors++; $display("FAIL flush_after got %0b/%0d want 1/400", wb_valid_o, wb_update_o.data); end
    step();
    checks++; if (occupancy_o !== 4'd0) begin errors++; $display("FAIL flush_after_occ got %0d want 0", occupancy_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_backpressure();
    test_full_pop_push();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
